// File: rtl/mjb_match.sv
// mjb_match: two-player MukJjiBba match engine; a GBB round picks the attacker, attack rounds score points.
// Optional collect-phase timeout is compiled in when MJB_TIMEOUT_EN is defined.
module mjb_match #(
  parameter int unsigned WIN_TARGET  = 3,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic               ck,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_valid,
  input  logic [1:0]         p1_hand,
  input  logic               p2_valid,
  input  logic [1:0]         p2_hand,
  output logic               p1_taken,
  output logic               p2_taken,
  output logic [2:0]         state,
  output logic               attacker,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               point_p1,
  output logic               point_p2,
  output logic               draw,
  output logic               timeout,
  output logic               match_done,
  output logic               winner
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GBB     = 3'd1,
    GBB_RES = 3'd2,
    ATK     = 3'd3,
    ATK_RES = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0]         HAND_NONE = 2'b00;
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_TARGET);

  state_t               st, st_n;
  logic [1:0]           h1, h2, h1_n, h2_n;
  logic                 t1_n, t2_n, att_n, win_n;
  logic                 pp1_n, pp2_n, draw_n;
  logic [SCORE_W-1:0]   s1_n, s2_n;

`ifdef MJB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            to_n;
`endif

  // Hand that loses against h: rock beats scissors, scissors beats paper, paper beats rock.
  function automatic logic [1:0] loser_of(input logic [1:0] h);
    case (h)
      2'b01:   loser_of = 2'b10;
      2'b10:   loser_of = 2'b11;
      2'b11:   loser_of = 2'b01;
      default: loser_of = 2'b00;
    endcase
  endfunction

  function automatic logic p1_wins(input logic [1:0] a, input logic [1:0] b);
    p1_wins = (b == loser_of(a));
  endfunction

  // Next-state and next-register values.
  always_comb begin
    st_n   = st;
    t1_n   = p1_taken;
    t2_n   = p2_taken;
    h1_n   = h1;
    h2_n   = h2;
    att_n  = attacker;
    s1_n   = p1_score;
    s2_n   = p2_score;
    win_n  = winner;
    pp1_n  = 1'b0;
    pp2_n  = 1'b0;
    draw_n = 1'b0;
`ifdef MJB_TIMEOUT_EN
    to_cnt_n = '0;
    to_n     = 1'b0;
`endif
    case (st)
      IDLE, DONE: begin
        if (start) begin
          st_n  = GBB;
          s1_n  = '0;
          s2_n  = '0;
          att_n = 1'b0;
        end
      end
      GBB, ATK: begin
        if (p1_valid && (p1_hand != HAND_NONE) && !p1_taken) begin
          t1_n = 1'b1;
          h1_n = p1_hand;
        end
        if (p2_valid && (p2_hand != HAND_NONE) && !p2_taken) begin
          t2_n = 1'b1;
          h2_n = p2_hand;
        end
        if (t1_n && t2_n) begin
          st_n = (st == GBB) ? GBB_RES : ATK_RES;
        end
`ifdef MJB_TIMEOUT_EN
        // A lone taken hand wins by default: the absent hand is filled with one it beats.
        else if (to_cnt == TO_LAST) begin
          to_n = 1'b1;
          if (t1_n) begin
            h2_n = loser_of(h1_n);
            st_n = (st == GBB) ? GBB_RES : ATK_RES;
          end else if (t2_n) begin
            h1_n = loser_of(h2_n);
            st_n = (st == GBB) ? GBB_RES : ATK_RES;
          end
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
`endif
      end
      GBB_RES: begin
        t1_n = 1'b0;
        t2_n = 1'b0;
        if (h1 == h2) begin
          draw_n = 1'b1;
          st_n   = GBB;
        end else begin
          att_n = ~p1_wins(h1, h2);
          st_n  = ATK;
        end
      end
      ATK_RES: begin
        t1_n = 1'b0;
        t2_n = 1'b0;
        if (h1 == h2) begin
          if (!attacker) begin
            s1_n  = p1_score + SCORE_W'(1);
            pp1_n = 1'b1;
            if (s1_n == SCORE_WIN) begin
              st_n  = DONE;
              win_n = 1'b0;
            end else begin
              st_n = GBB;
            end
          end else begin
            s2_n  = p2_score + SCORE_W'(1);
            pp2_n = 1'b1;
            if (s2_n == SCORE_WIN) begin
              st_n  = DONE;
              win_n = 1'b1;
            end else begin
              st_n = GBB;
            end
          end
        end else begin
          att_n = ~p1_wins(h1, h2);
          st_n  = ATK;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ck) begin
    if (reset) begin
      st <= IDLE;
    end else begin
      st <= st_n;
    end
  end

  // Datapath registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      p1_taken <= 1'b0;
      p2_taken <= 1'b0;
      h1       <= '0;
      h2       <= '0;
      attacker <= 1'b0;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= 1'b0;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      draw     <= 1'b0;
    end else begin
      p1_taken <= t1_n;
      p2_taken <= t2_n;
      h1       <= h1_n;
      h2       <= h2_n;
      attacker <= att_n;
      p1_score <= s1_n;
      p2_score <= s2_n;
      winner   <= win_n;
      point_p1 <= pp1_n;
      point_p2 <= pp2_n;
      draw     <= draw_n;
    end
  end

`ifdef MJB_TIMEOUT_EN
  always_ff @(posedge ck) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_n;
      timeout <= to_n;
    end
  end
`else
  logic unused_to_cfg;
  assign unused_to_cfg = ^TO_W'(TIMEOUT_CYC);
  assign timeout       = 1'b0;
`endif

  assign state      = 3'(st);
  assign match_done = (st == DONE);

endmodule

// File: tb/tb_mjb_match.sv
// Bench for mjb_match: directed vector table, reset/timeout sequences, then random play against a reference model.
module tb_mjb_match;
  localparam int unsigned WIN_TARGET  = 2;
  localparam int unsigned SCORE_W     = 3;
  localparam int unsigned TIMEOUT_CYC = 4;
  localparam int unsigned TO_W        = 2;

  logic               ck = 1'b0;
  logic               reset, start, p1_valid, p2_valid;
  logic [1:0]         p1_hand, p2_hand;
  logic               p1_taken, p2_taken, attacker;
  logic [2:0]         state;
  logic [SCORE_W-1:0] p1_score, p2_score;
  logic               point_p1, point_p2, draw, timeout, match_done, winner;

  mjb_match #(
    .WIN_TARGET(WIN_TARGET), .SCORE_W(SCORE_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .ck(ck), .reset(reset), .start(start),
    .p1_valid(p1_valid), .p1_hand(p1_hand), .p2_valid(p2_valid), .p2_hand(p2_hand),
    .p1_taken(p1_taken), .p2_taken(p2_taken), .state(state), .attacker(attacker),
    .p1_score(p1_score), .p2_score(p2_score), .point_p1(point_p1), .point_p2(point_p2),
    .draw(draw), .timeout(timeout), .match_done(match_done), .winner(winner)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases as integers, hands 1..3, winner by modular arithmetic.
  int m_st, m_t1, m_t2, m_h1, m_h2, m_att, m_s1, m_s2, m_win, m_cnt, m_fw;
  bit m_forced, m_pp1, m_pp2, m_draw, m_to;

  function automatic bit beats(input int a, input int b);
    return ((b - a + 3) % 3) == 1;
  endfunction

  task automatic model_edge();
    m_pp1 = 0; m_pp2 = 0; m_draw = 0; m_to = 0;
    if (reset) begin
      m_st = 0; m_t1 = 0; m_t2 = 0; m_h1 = 0; m_h2 = 0; m_att = 0;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_fw = 0; m_forced = 0;
      return;
    end
    case (m_st)
      0, 5: if (start) begin m_st = 1; m_s1 = 0; m_s2 = 0; m_att = 0; m_cnt = 0; end
      1, 3: begin
        if (p1_valid && p1_hand != 0 && m_t1 == 0) begin m_t1 = 1; m_h1 = int'(p1_hand); end
        if (p2_valid && p2_hand != 0 && m_t2 == 0) begin m_t2 = 1; m_h2 = int'(p2_hand); end
        if (m_t1 == 1 && m_t2 == 1) m_st = m_st + 1;
        else begin
`ifdef MJB_TIMEOUT_EN
          if (m_cnt == int'(TIMEOUT_CYC) - 1) begin
            m_to = 1; m_cnt = 0;
            if (m_t1 == 1) begin m_forced = 1; m_fw = 0; m_st = m_st + 1; end
            else if (m_t2 == 1) begin m_forced = 1; m_fw = 1; m_st = m_st + 1; end
          end else m_cnt++;
`endif
        end
      end
      2: begin
        m_t1 = 0; m_t2 = 0; m_cnt = 0;
        if (m_forced) begin m_att = m_fw; m_st = 3; end
        else if (m_h1 == m_h2) begin m_draw = 1; m_st = 1; end
        else begin m_att = beats(m_h1, m_h2) ? 0 : 1; m_st = 3; end
        m_forced = 0;
      end
      4: begin
        m_t1 = 0; m_t2 = 0; m_cnt = 0;
        if (!m_forced && m_h1 == m_h2) begin
          if (m_att == 0) begin
            m_s1++; m_pp1 = 1;
            if (m_s1 == int'(WIN_TARGET)) begin m_st = 5; m_win = 0; end else m_st = 1;
          end else begin
            m_s2++; m_pp2 = 1;
            if (m_s2 == int'(WIN_TARGET)) begin m_st = 5; m_win = 1; end else m_st = 1;
          end
        end else begin
          m_att = m_forced ? m_fw : (beats(m_h1, m_h2) ? 0 : 1);
          m_st = 3;
        end
        m_forced = 0;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic step();
    @(posedge ck);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit s, input bit v1, input int h1, input bit v2, input int h2);
    start = s; p1_valid = v1; p1_hand = 2'(h1); p2_valid = v2; p2_hand = 2'(h2);
  endtask

  task automatic compare_model(input int cyc);
    string t;
    t = $sformatf("rnd%0d", cyc);
    check({t, " state"}, int'(state), m_st);
    check({t, " p1_taken"}, int'(p1_taken), m_t1);
    check({t, " p2_taken"}, int'(p2_taken), m_t2);
    check({t, " attacker"}, int'(attacker), m_att);
    check({t, " p1_score"}, int'(p1_score), m_s1);
    check({t, " p2_score"}, int'(p2_score), m_s2);
    check({t, " point_p1"}, int'(point_p1), int'(m_pp1));
    check({t, " point_p2"}, int'(point_p2), int'(m_pp2));
    check({t, " draw"}, int'(draw), int'(m_draw));
    check({t, " timeout"}, int'(timeout), int'(m_to));
    check({t, " match_done"}, int'(match_done), (m_st == 5) ? 1 : 0);
    if (m_st == 5) check({t, " winner"}, int'(winner), m_win);
  endtask

  typedef struct {
    bit s; bit v1; int h1; bit v2; int h2;
    int e_st; bit e_t1; bit e_t2; int e_att; int e_s1; int e_s2;
    bit e_pp1; bit e_pp2; bit e_draw; bit e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit v1, input int h1, input bit v2, input int h2,
                     input int est, input bit et1, input bit et2, input int eatt,
                     input int es1, input int es2, input bit epp1, input bit epp2,
                     input bit edraw, input bit edone);
    vec_t v;
    v = '{s, v1, h1, v2, h2, est, et1, et2, eatt, es1, es2, epp1, epp2, edraw, edone};
    tbl.push_back(v);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("reset state", int'(state), 0);
    check("reset taken", int'({p1_taken, p2_taken}), 0);
    check("reset scores", int'({p1_score, p2_score}), 0);
    check("reset pulses", int'({point_p1, point_p2, draw, timeout}), 0);
    check("reset done/winner/att", int'({match_done, winner, attacker}), 0);

    //   s v1 h1 v2 h2 | st t1 t2 att s1 s2 pp1 pp2 drw done
    add(0, 1, 1, 1, 2,   0, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(0, 1, 1, 1, 2,   2, 1, 1, 0,  0, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(0, 1, 3, 1, 3,   4, 1, 1, 0,  0, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 1,  0,  0,  0);
    add(0, 1, 3, 1, 3,   2, 1, 1, 0,  1, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 0,  0,  1,  0);
    add(0, 1, 1, 1, 2,   2, 1, 1, 0,  1, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 0,  1, 0, 0,  0,  0,  0);
    add(0, 1, 1, 1, 3,   4, 1, 1, 0,  1, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 1,  1, 0, 0,  0,  0,  0);
    add(0, 1, 2, 0, 0,   3, 1, 0, 1,  1, 0, 0,  0,  0,  0);
    add(0, 1, 1, 1, 2,   4, 1, 1, 1,  1, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 1,  1, 1, 0,  1,  0,  0);
    add(0, 1, 1, 1, 2,   2, 1, 1, 1,  1, 1, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 0,  1, 1, 0,  0,  0,  0);
    add(0, 1, 3, 1, 3,   4, 1, 1, 0,  1, 1, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   5, 0, 0, 0,  2, 1, 1,  0,  0,  1);
    add(0, 1, 1, 1, 2,   5, 0, 0, 0,  2, 1, 0,  0,  0,  1);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(0, 1, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(0, 1, 1, 1, 2,   2, 1, 1, 0,  0, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 0,  0, 0, 0,  0,  0,  0);
    add(0, 1, 3, 1, 3,   4, 1, 1, 0,  0, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 1,  0,  0,  0);
    add(0, 1, 1, 1, 2,   2, 1, 1, 0,  1, 0, 0,  0,  0,  0);
    add(0, 0, 0, 0, 0,   3, 0, 0, 0,  1, 0, 0,  0,  0,  0);
    add(0, 1, 2, 1, 2,   4, 1, 1, 0,  1, 0, 0,  0,  0,  0);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].s, tbl[i].v1, tbl[i].h1, tbl[i].v2, tbl[i].h2);
      step();
      check({t, " state"}, int'(state), tbl[i].e_st);
      check({t, " p1_taken"}, int'(p1_taken), int'(tbl[i].e_t1));
      check({t, " p2_taken"}, int'(p2_taken), int'(tbl[i].e_t2));
      check({t, " attacker"}, int'(attacker), tbl[i].e_att);
      check({t, " p1_score"}, int'(p1_score), tbl[i].e_s1);
      check({t, " p2_score"}, int'(p2_score), tbl[i].e_s2);
      check({t, " point_p1"}, int'(point_p1), int'(tbl[i].e_pp1));
      check({t, " point_p2"}, int'(point_p2), int'(tbl[i].e_pp2));
      check({t, " draw"}, int'(draw), int'(tbl[i].e_draw));
      check({t, " match_done"}, int'(match_done), int'(tbl[i].e_done));
      if (tbl[i].e_done) check({t, " winner"}, int'(winner), 0);
    end

    // Reset while in ATK_RES with a point pending; reset beats start and valid.
    drive(1, 1, 1, 1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_atkres state", int'(state), 0);
    check("rst_atkres p1_score", int'(p1_score), 0);
    check("rst_atkres point_p1", int'(point_p1), 0);
    check("rst_atkres taken", int'({p1_taken, p2_taken}), 0);

    // Only p2 offers in GBB.
    drive(1, 0, 0, 0, 0); step();
    check("to start state", int'(state), 1);
    drive(0, 0, 0, 1, 2); step();
    check("to p2 taken", int'(p2_taken), 1);
    drive(0, 0, 0, 0, 0); step(); step();
    check("to wait state", int'(state), 1);
    step();
`ifdef MJB_TIMEOUT_EN
    check("to pulse", int'(timeout), 1);
    check("to res state", int'(state), 2);
    step();
    check("to atk state", int'(state), 3);
    check("to attacker", int'(attacker), 1);
    check("to pulse clear", int'(timeout), 0);
`else
    check("to pulse", int'(timeout), 0);
    check("to hold state", int'(state), 1);
    step();
    check("to hold state2", int'(state), 1);
    check("to hold p2_taken", int'(p2_taken), 1);
`endif

    // Random play against the reference model.
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
      step();
      compare_model(c);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
